// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, scoreboard limits and the sequencing-state encoding for the
// hazard controller and its scoreboard.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int OPCODE_WIDTH   = 7;
  localparam int NUM_REGS       = 32;

  // EX, MEM and WB can each hold one write to the same register.
  localparam logic [1:0] CNT_MAX = 2'd3;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register in-flight write counters: bumped when ID issues a write and
// decremented when WB retires one; x0 is never tracked.
module hz_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue,
  input  reg_addr_t           issue_rd,
  input  logic                retire,
  input  reg_addr_t           retire_rd,
  input  reg_addr_t           rd_addr_a,
  input  reg_addr_t           rd_addr_b,
  output logic [1:0]          rd_cnt_a,
  output logic [1:0]          rd_cnt_b,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [1:0] cnt_q [NUM_REGS];

  // Illegal steps (overflow/underflow) hold the current value.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    if (inc && !dec)
      return (cnt == CNT_MAX) ? cnt : cnt + 2'd1;
    else if (dec && !inc)
      return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    return cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= 2'd0;
    end else begin
      cnt_q[0] <= 2'd0;
      for (int r = 1; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_step(cnt_q[r],
                             issue  && (issue_rd  == reg_addr_t'(r)),
                             retire && (retire_rd == reg_addr_t'(r)));
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      if (issue && (issue_rd != '0) && !(retire && (retire_rd == issue_rd)) &&
          (cnt_q[issue_rd] == CNT_MAX))
        $error("hz_scoreboard: overflow on x%0d", issue_rd);
      if (retire && (retire_rd != '0) && !(issue && (issue_rd == retire_rd)) &&
          (cnt_q[retire_rd] == 2'd0))
        $error("hz_scoreboard: underflow on x%0d", retire_rd);
    end
  end
`endif

  assign rd_cnt_a = cnt_q[rd_addr_a];
  assign rd_cnt_b = cnt_q[rd_addr_b];

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++)
      busy_mask[r] = (cnt_q[r] != 2'd0);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage sequencing for the 5-stage core: hazard detection, flush/stall/run
// priority, PC/IF-ID/ID-EX controls and stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter bit WB_BYPASS  = 1'b1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           id_rd,
  input  logic                 id_RegWrite,
  input  logic                 ex_valid,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_MemRead,
  input  logic                 wb_RegWrite,
  input  logic [4:0]           wb_rd,
  input  logic                 branch_taken,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic [31:0]          busy_mask,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  logic      issue;
  logic      retire;
  logic [1:0] cnt_rs1;
  logic [1:0] cnt_rs2;
  logic      haz_rs1;
  logic      haz_rs2;
  hz_state_t state;

  // Forwarding covers everything except a load still in EX; without it any
  // pending write blocks, unless the write-through register file delivers it now.
  function automatic logic rs_hazard(input logic      uses,
                                     input reg_addr_t rs,
                                     input logic [1:0] cnt,
                                     input logic      idv,
                                     input logic      exv,
                                     input logic      exmr,
                                     input reg_addr_t exrd,
                                     input logic      ret,
                                     input reg_addr_t wbrd);
    logic hit;
    hit = uses && (rs != '0) && idv;
    if (FORWARDING)
      return hit && exv && exmr && (exrd == rs);
    return hit && (cnt != 2'd0) &&
           !(WB_BYPASS && (cnt == 2'd1) && ret && (wbrd == rs));
  endfunction

  assign retire = wb_RegWrite && (wb_rd != '0);
  assign issue  = id_valid && !id_ex_bubble && id_RegWrite && (id_rd != '0);

  hz_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .issue_rd  (id_rd),
    .retire    (retire),
    .retire_rd (wb_rd),
    .rd_addr_a (id_rs1),
    .rd_addr_b (id_rs2),
    .rd_cnt_a  (cnt_rs1),
    .rd_cnt_b  (cnt_rs2),
    .busy_mask (busy_mask)
  );

  assign haz_rs1 = rs_hazard(id_uses_rs1, id_rs1, cnt_rs1, id_valid, ex_valid,
                             ex_MemRead, ex_rd, retire, wb_rd);
  assign haz_rs2 = rs_hazard(id_uses_rs2, id_rs2, cnt_rs2, id_valid, ex_valid,
                             ex_MemRead, ex_rd, retire, wb_rd);

  // Flush outranks stall: a squashed ID has no hazard worth waiting for.
  always_comb begin
    state = HZ_RUN;
    if (rst)
      state = HZ_RUN;
    else if (branch_taken)
      state = HZ_FLUSH;
    else if (haz_rs1 || haz_rs2)
      state = HZ_STALL;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state)
      HZ_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      HZ_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == HZ_STALL)
        stall_cnt <= stall_cnt + 1'b1;
      if (state == HZ_FLUSH)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three configurations share stimulus, and the
// instances not under test are held in reset.
module tb_hazard_ctrl;

  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;

  logic clk = 1'b0;
  logic rst_ld, rst_fb, rst_fn;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_RegWrite;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
  logic ex_valid, ex_MemRead, wb_RegWrite, branch_taken;

  logic pw_ld, iw_ld, fl_ld, bb_ld, pw_fb, iw_fb, fl_fb, bb_fb, pw_fn, iw_fn, fl_fn, bb_fn;
  logic [31:0] busy_ld, busy_fb, busy_fn;
  logic [31:0] sc_ld, fc_ld, sc_fb, fc_fb, sc_fn, fc_fn;
  logic [3:0] ctl_ld, ctl_fb, ctl_fn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ctl_ld = {pw_ld, iw_ld, fl_ld, bb_ld};
  assign ctl_fb = {pw_fb, iw_fb, fl_fb, bb_fb};
  assign ctl_fn = {pw_fn, iw_fn, fl_fn, bb_fn};

  hazard_ctrl #(.FORWARDING(1'b1), .WB_BYPASS(1'b1), .CNT_WIDTH(32)) dut_ld (
    .clk(clk), .rst(rst_ld), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .branch_taken(branch_taken),
    .pc_write(pw_ld), .if_id_write(iw_ld), .if_id_flush(fl_ld), .id_ex_bubble(bb_ld),
    .busy_mask(busy_ld), .stall_cnt(sc_ld), .flush_cnt(fc_ld));

  hazard_ctrl #(.FORWARDING(1'b0), .WB_BYPASS(1'b1), .CNT_WIDTH(32)) dut_fb (
    .clk(clk), .rst(rst_fb), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .branch_taken(branch_taken),
    .pc_write(pw_fb), .if_id_write(iw_fb), .if_id_flush(fl_fb), .id_ex_bubble(bb_fb),
    .busy_mask(busy_fb), .stall_cnt(sc_fb), .flush_cnt(fc_fb));

  hazard_ctrl #(.FORWARDING(1'b0), .WB_BYPASS(1'b0), .CNT_WIDTH(32)) dut_fn (
    .clk(clk), .rst(rst_fn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .branch_taken(branch_taken),
    .pc_write(pw_fn), .if_id_write(iw_fn), .if_id_flush(fl_fn), .id_ex_bubble(bb_fn),
    .busy_mask(busy_fn), .stall_cnt(sc_fn), .flush_cnt(fc_fn));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = rd; id_RegWrite = rw;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic mr);
    ex_valid = v; ex_rd = rd; ex_MemRead = mr;
  endtask

  task automatic set_wb(input logic rw, input logic [4:0] rd);
    wb_RegWrite = rw; wb_rd = rd;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_ex(1'b0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0);
    branch_taken = 1'b0;
  endtask

  task automatic select(input logic ld, input logic fb, input logic fn);
    idle();
    rst_ld = 1'b1; rst_fb = 1'b1; rst_fn = 1'b1;
    tick();
    rst_ld = !ld; rst_fb = !fb; rst_fn = !fn;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_ld = 1'b1; rst_fb = 1'b1; rst_fn = 1'b1;
    // load-use pattern plus branch while in reset: outputs must stay RUN
    set_ex(1'b1, 5'd5, 1'b1);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1);
    branch_taken = 1'b1;
    #1;
    n_checks++; if (ctl_ld !== C_RUN) begin n_fail++; $display("FAIL rst_ctl_ld: got %b expected %b", ctl_ld, C_RUN); end
    n_checks++; if (ctl_fb !== C_RUN) begin n_fail++; $display("FAIL rst_ctl_fb: got %b expected %b", ctl_fb, C_RUN); end
    tick();
    n_checks++; if (busy_ld !== 32'd0) begin n_fail++; $display("FAIL rst_busy_ld: got %h expected 0", busy_ld); end
    n_checks++; if (sc_ld !== 32'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d expected 0", sc_ld); end
    n_checks++; if (fc_ld !== 32'd0) begin n_fail++; $display("FAIL rst_flush_cnt: got %0d expected 0", fc_ld); end
    n_checks++; if (busy_fn !== 32'd0) begin n_fail++; $display("FAIL rst_busy_fn: got %h expected 0", busy_fn); end
    idle();
  endtask

  task automatic test_load_use();
    select(1'b1, 1'b0, 1'b0);
    // lw x5 in EX, add x6,x5,x1 in ID
    set_ex(1'b1, 5'd5, 1'b1);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1);
    #1;
    n_checks++; if (ctl_ld !== C_STALL) begin n_fail++; $display("FAIL lu_stall: got %b expected %b", ctl_ld, C_STALL); end
    tick();
    n_checks++; if (sc_ld !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", sc_ld); end
    n_checks++; if (busy_ld !== 32'd0) begin n_fail++; $display("FAIL lu_no_issue: got %h expected 0", busy_ld); end
    set_ex(1'b0, 5'd0, 1'b0);
    #1;
    n_checks++; if (ctl_ld !== C_RUN) begin n_fail++; $display("FAIL lu_run: got %b expected %b", ctl_ld, C_RUN); end
    tick();
    n_checks++; if (sc_ld !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt_hold: got %0d expected 1", sc_ld); end
    n_checks++; if (busy_ld !== 32'h0000_0040) begin n_fail++; $display("FAIL lu_issue_x6: got %h expected 00000040", busy_ld); end
    // load into x1 hits rs2
    set_ex(1'b1, 5'd1, 1'b1);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++; if (ctl_ld !== C_STALL) begin n_fail++; $display("FAIL lu_rs2: got %b expected %b", ctl_ld, C_STALL); end
    // matching rd but operands not read; load into x0 read as x0
    set_id(1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    n_checks++; if (ctl_ld !== C_RUN) begin n_fail++; $display("FAIL lu_unused_rs: got %b expected %b", ctl_ld, C_RUN); end
    set_ex(1'b1, 5'd0, 1'b1);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++; if (ctl_ld !== C_RUN) begin n_fail++; $display("FAIL lu_x0: got %b expected %b", ctl_ld, C_RUN); end
    // non-load producer in EX is forwarded
    set_ex(1'b1, 5'd5, 1'b0);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++; if (ctl_ld !== C_RUN) begin n_fail++; $display("FAIL lu_alu_fwd: got %b expected %b", ctl_ld, C_RUN); end
    idle();
  endtask

  task automatic test_flush();
    select(1'b1, 1'b0, 1'b0);
    set_ex(1'b1, 5'd5, 1'b1);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1);
    branch_taken = 1'b1;
    #1;
    n_checks++; if (ctl_ld !== C_FLUSH) begin n_fail++; $display("FAIL fl_ctl: got %b expected %b", ctl_ld, C_FLUSH); end
    tick();
    n_checks++; if (fc_ld !== 32'd1) begin n_fail++; $display("FAIL fl_flush_cnt: got %0d expected 1", fc_ld); end
    n_checks++; if (sc_ld !== 32'd0) begin n_fail++; $display("FAIL fl_stall_cnt: got %0d expected 0", sc_ld); end
    n_checks++; if (busy_ld !== 32'd0) begin n_fail++; $display("FAIL fl_no_issue: got %h expected 0", busy_ld); end
    idle();
  endtask

  task automatic test_scoreboard_stall();
    select(1'b0, 1'b1, 1'b1);
    // addi x3 issues from ID
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    #1;
    n_checks++; if (ctl_fb !== C_RUN) begin n_fail++; $display("FAIL sb_issue_run: got %b expected %b", ctl_fb, C_RUN); end
    tick();
    n_checks++; if (busy_fb !== 32'h0000_0008) begin n_fail++; $display("FAIL sb_busy3: got %h expected 00000008", busy_fb); end
    // store-like reader of x3 (no destination)
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (ctl_fb !== C_STALL) begin n_fail++; $display("FAIL sb_stall_fb_c%0d: got %b expected %b", c, ctl_fb, C_STALL); end
      n_checks++; if (ctl_fn !== C_STALL) begin n_fail++; $display("FAIL sb_stall_fn_c%0d: got %b expected %b", c, ctl_fn, C_STALL); end
      tick();
    end
    set_wb(1'b1, 5'd3);
    #1;
    n_checks++; if (ctl_fb !== C_RUN) begin n_fail++; $display("FAIL sb_wb_bypass: got %b expected %b", ctl_fb, C_RUN); end
    n_checks++; if (ctl_fn !== C_STALL) begin n_fail++; $display("FAIL sb_no_bypass: got %b expected %b", ctl_fn, C_STALL); end
    tick();
    n_checks++; if (busy_fb !== 32'd0) begin n_fail++; $display("FAIL sb_busy_clear: got %h expected 0", busy_fb); end
    n_checks++; if (sc_fb !== 32'd2) begin n_fail++; $display("FAIL sb_stall_cnt_fb: got %0d expected 2", sc_fb); end
    n_checks++; if (sc_fn !== 32'd3) begin n_fail++; $display("FAIL sb_stall_cnt_fn: got %0d expected 3", sc_fn); end
    set_wb(1'b0, 5'd0);
    #1;
    n_checks++; if (ctl_fn !== C_RUN) begin n_fail++; $display("FAIL sb_fn_resume: got %b expected %b", ctl_fn, C_RUN); end
    idle();
  endtask

  task automatic test_x0();
    select(1'b0, 1'b1, 1'b0);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    n_checks++; if (busy_fb !== 32'd0) begin n_fail++; $display("FAIL x0_busy: got %h expected 0", busy_fb); end
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    set_wb(1'b1, 5'd0);
    #1;
    n_checks++; if (ctl_fb !== C_RUN) begin n_fail++; $display("FAIL x0_reader: got %b expected %b", ctl_fb, C_RUN); end
    tick();
    n_checks++; if (busy_fb !== 32'd0) begin n_fail++; $display("FAIL x0_busy_after: got %h expected 0", busy_fb); end
    idle();
  endtask

  task automatic test_back_to_back();
    select(1'b0, 1'b1, 1'b0);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
    tick();
    n_checks++; if (busy_fb !== 32'h0000_0080) begin n_fail++; $display("FAIL b2b_first: got %h expected 00000080", busy_fb); end
    set_wb(1'b1, 5'd7);
    tick();
    n_checks++; if (busy_fb !== 32'h0000_0080) begin n_fail++; $display("FAIL b2b_same_cycle: got %h expected 00000080", busy_fb); end
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    n_checks++; if (busy_fb !== 32'd0) begin n_fail++; $display("FAIL b2b_drain: got %h expected 0", busy_fb); end
    idle();
  endtask

  task automatic test_mid_reset();
    select(1'b0, 1'b1, 1'b0);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();
    tick();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 9; c++) tick();
    n_checks++; if (sc_fb !== 32'd9) begin n_fail++; $display("FAIL mr_stall_cnt9: got %0d expected 9", sc_fb); end
    n_checks++; if (busy_fb !== 32'h0000_0004) begin n_fail++; $display("FAIL mr_busy2: got %h expected 00000004", busy_fb); end
    rst_fb = 1'b1;
    #1;
    n_checks++; if (ctl_fb !== C_RUN) begin n_fail++; $display("FAIL mr_ctl_in_rst: got %b expected %b", ctl_fb, C_RUN); end
    tick();
    n_checks++; if (busy_fb !== 32'd0) begin n_fail++; $display("FAIL mr_busy_cleared: got %h expected 0", busy_fb); end
    n_checks++; if (sc_fb !== 32'd0) begin n_fail++; $display("FAIL mr_stall_cleared: got %0d expected 0", sc_fb); end
    rst_fb = 1'b0;
    #1;
    n_checks++; if (ctl_fb !== C_RUN) begin n_fail++; $display("FAIL mr_after_rst: got %b expected %b", ctl_fb, C_RUN); end
    idle();
    tick();
  endtask

  initial begin
    idle();
    rst_ld = 1'b1; rst_fb = 1'b1; rst_fn = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_flush();
    test_scoreboard_stall();
    test_x0();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
